// File: rtl/control_sequencer.sv
// Micro-sequencer for a small accumulator CPU: FETCH/DECODE/EXEC with an extra MEM
// cycle for loads and stores, and a HALT state that only reset can leave.
module control_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] c_opcode,
  input  logic       flag_z,
  input  logic       flag_c,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       c_imm,
  output logic       c_a,
  output logic       c_b,
  output logic       a_out,
  output logic       alu_out,
  output logic [2:0] alu_op,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       out_we,
  output logic       halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign state = state_q;

  // Outputs depend only on the registered state plus the live opcode and flags,
  // so a flag that changes during EXEC of a conditional jump is seen immediately.
  always_comb begin
    state_d = S_FETCH;
    ir_load = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    c_imm   = 1'b0;
    c_a     = 1'b0;
    c_b     = 1'b0;
    a_out   = 1'b0;
    alu_out = 1'b0;
    alu_op  = 3'd0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    out_we  = 1'b0;
    halted  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (c_opcode)
          4'h1: begin c_imm = 1'b1; c_a = 1'b1; end
          4'h2, 4'h3: begin c_imm = 1'b1; state_d = S_MEM; end
          4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
            alu_out = 1'b1;
            c_a     = 1'b1;
            alu_op  = 3'(c_opcode - 4'd4);
          end
          4'h9: begin a_out = 1'b1; c_b = 1'b1; end
          4'hA: begin c_imm = 1'b1; pc_load = 1'b1; end
          4'hB: begin c_imm = 1'b1; pc_load = flag_z; end
          4'hC: begin c_imm = 1'b1; pc_load = flag_c; end
          4'hD: begin a_out = 1'b1; out_we = 1'b1; end
          4'hF: state_d = S_HALT;
          default: ;
        endcase
      end
      // The opcode is still held in the instruction register during MEM.
      S_MEM: begin
        if (c_opcode == 4'h2) begin
          mem_rd = 1'b1;
          c_a    = 1'b1;
        end else if (c_opcode == 4'h3) begin
          a_out  = 1'b1;
          mem_wr = 1'b1;
        end
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule
